stack_pointer: RTL and testbench



---
 rtl/stack_pointer_pkg.sv | 5 +
 rtl/stack_pointer_if.sv | 14 +
 rtl/stack_pointer.sv | 25 ++
 tb/tb_stack_pointer.sv | 58 +++++
 4 files changed

// File: rtl/stack_pointer_pkg.sv
// stack_pointer_pkg: shared CPU constants so the datapath and the scratch RAM agree on the pointer width
package stack_pointer_pkg;
  localparam int SP_WIDTH = 8;
  localparam logic [SP_WIDTH-1:0] SP_RESET_VAL = 8'h00;
endpackage

// File: rtl/stack_pointer_if.sv
// stack_pointer_if: control-unit command bus and pointer output of the stack pointer
interface stack_pointer_if
  import stack_pointer_pkg::*;
#(
  parameter int WIDTH = SP_WIDTH
);
  logic [WIDTH-1:0] data;
  logic             ld;
  logic             incr;
  logic             decr;
  logic [WIDTH-1:0] out;
  modport master (output data, ld, incr, decr, input out);
  modport slave (input data, ld, incr, decr, output out);
endinterface

// File: rtl/stack_pointer.sv
// stack_pointer: registered stack-top address with load, increment (pop) and decrement (push)
module stack_pointer
  import stack_pointer_pkg::*;
#(
  parameter int               WIDTH     = SP_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = SP_RESET_VAL
) (
  input logic           CLK,
  input logic           RST,
  stack_pointer_if.slave sp
);
  logic [WIDTH-1:0] out_q, out_d;
  // next pointer: load beats increment, increment beats decrement, otherwise hold
  always_comb begin
    out_d = sp.ld   ? sp.data :
            sp.incr ? out_q + 1'b1 :
            sp.decr ? out_q - 1'b1 : out_q;
  end
  // reset overrides every command on the same edge
  always_ff @(posedge CLK) begin
    if (RST) out_q <= RESET_VAL;
    else     out_q <= out_d;
  end
  assign sp.out = out_q;
endmodule

// File: tb/tb_stack_pointer.sv
// tb_stack_pointer: directed checks of priority, stepping, wrap-around and hold
module tb_stack_pointer;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int total = 0;
  int bad = 0;
  stack_pointer_if sp ();
  stack_pointer dut (.CLK(CLK), .RST(RST), .sp(sp));
  always #5 CLK = ~CLK;
  task automatic step(input logic r, input logic l, input logic i, input logic d,
                      input logic [7:0] dat, input logic [7:0] exp, input string tag);
    @(negedge CLK);
    RST = r;
    sp.ld = l;
    sp.incr = i;
    sp.decr = d;
    sp.data = dat;
    @(posedge CLK);
    #1;
    total++;
    assert (sp.out === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, sp.out, exp);
    end
  endtask
  initial begin
    sp.ld = 1'b0;
    sp.incr = 1'b0;
    sp.decr = 1'b0;
    sp.data = 8'h00;
    step(1, 0, 0, 0, 8'hAA, 8'h00, "reset");
    step(0, 1, 0, 0, 8'h15, 8'h15, "load");
    step(0, 1, 1, 1, 8'h28, 8'h28, "load_beats_step");
    step(1, 1, 1, 1, 8'h28, 8'h00, "reset_beats_all");
    step(0, 1, 0, 1, 8'h15, 8'h15, "load_beats_decr");
    step(0, 0, 1, 0, 8'h00, 8'h16, "incr");
    step(0, 0, 1, 1, 8'h00, 8'h17, "incr_beats_decr");
    step(0, 0, 0, 1, 8'h00, 8'h16, "decr1");
    step(0, 0, 0, 1, 8'h00, 8'h15, "decr2");
    step(0, 1, 0, 0, 8'hFF, 8'hFF, "load_ff");
    step(0, 0, 1, 0, 8'h00, 8'h00, "wrap_up");
    step(0, 1, 0, 0, 8'h00, 8'h00, "load_00");
    step(0, 0, 0, 1, 8'h00, 8'hFF, "wrap_down");
    step(0, 0, 0, 0, 8'h5A, 8'hFF, "hold1");
    step(0, 0, 0, 0, 8'hA5, 8'hFF, "hold2");
    step(0, 0, 0, 0, 8'h5A, 8'hFF, "hold3");
    step(0, 1, 0, 0, 8'h80, 8'h80, "load_80");
    step(1, 0, 0, 1, 8'h33, 8'h00, "reset_mid");
    step(0, 0, 0, 1, 8'h33, 8'hFF, "after_reset_decr");
    step(1, 0, 1, 0, 8'h33, 8'h00, "reset_again");
    step(0, 0, 1, 0, 8'h33, 8'h01, "after_reset_incr");
    step(0, 1, 0, 0, 8'h7F, 8'h7F, "load_7f");
    step(0, 0, 1, 0, 8'h00, 8'h80, "carry_chain");
    step(0, 0, 0, 1, 8'h00, 8'h7F, "borrow_chain");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
